sys_cmd_master: RTL
===================

Name: sys_cmd_master

Overview:
- Host-side command initiator for the system's UART command protocol.
- Accepts one command at a time on a valid/ready request port and serializes it into the frame byte sequence for a byte-level UART TX.
- Collects the system's response bytes from a byte-level UART RX and returns one assembled 16-bit result per command, or a timeout flag.
- Used as the far-end driver in system-level benches and in host bridge FPGAs.

Parameters:
- TIMEOUT_CYC, 65535: CLK cycles allowed between response bytes before the command is aborted; must be >= 1.
- TO_W, 16: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- CLK  in  1  single block clock.
- RST  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  block idle, request accepted when cmd_valid && cmd_ready.
- cmd_type  in  2  0=REG_WR, 1=REG_RD, 2=ALU_OP, 3=ALU_NOP.
- cmd_addr  in  4  register address.
- cmd_wdata  in  8  write data.
- cmd_op_a  in  8  ALU operand A.
- cmd_op_b  in  8  ALU operand B.
- cmd_fun  in  4  ALU function.
- tx_byte  out  8  byte to UART TX.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  UART TX accepts the byte this cycle.
- rx_byte  in  8  byte from UART RX.
- rx_valid  in  1  one-cycle pulse, rx_byte valid.
- rsp_data  out  16  assembled response.
- rsp_valid  out  1  one-cycle pulse, command completed.
- rsp_timeout  out  1  one-cycle pulse, command aborted.
- rx_stray  out  1  one-cycle pulse, rx byte arrived while no response was expected.

Behaviour:
- Reset: state IDLE, cmd_ready=1, tx_valid=0, tx_byte=0, rsp_data=0, rsp_valid=0, rsp_timeout=0, rx_stray=0, all counters 0. An active reset mid-command aborts the command with no response pulse.
- Command capture: all cmd_* fields are registered on acceptance. cmd_ready=0 from the next cycle until the command returns to IDLE.
- Frames (byte order fixed; addr and fun are zero-extended to 8 bits):
  - REG_WR: AA, {0,addr}, wdata. Expects 0 response bytes.
  - REG_RD: BB, {0,addr}. Expects 1 response byte.
  - ALU_OP: CC, op_a, op_b, {0,fun}. Expects 2 response bytes.
  - ALU_NOP: DD, {0,fun}. Expects 2 response bytes.
- FSM states: IDLE -> SEND on accept; SEND -> RESP after the last byte is accepted (or -> FIN for REG_WR); RESP -> FIN when the expected byte count is reached; RESP -> IDLE on timeout; FIN -> IDLE.
- SEND:
  - tx_valid=1 from the cycle after acceptance.
  - A byte transfers when tx_valid && tx_ready; the byte index increments and the next byte is presented the following cycle (back-to-back is allowed).
  - tx_byte is held stable while tx_ready=0.
  - tx_valid drops in the cycle after the last transfer.
- RESP:
  - Bytes are stored low first: the first rx byte goes to rsp_data[7:0], the second to rsp_data[15:8].
  - For REG_RD, rsp_data[15:8]=0.
  - rsp_data is cleared to 0 on command acceptance.
- FIN: rsp_valid=1 for exactly one cycle, with rsp_data stable in that cycle and held until the next acceptance. REG_WR completes with rsp_data=0.
- Latency: with tx_ready tied high and a command accepted in cycle N:
  - First byte is presented in N+1.
  - REG_WR: last byte transfers in N+3; rsp_valid in N+4.
  - Response commands: rsp_valid is asserted 1 cycle after the final rx_valid.
- Timeout:
  - The counter clears on entering RESP and on every rx_valid in RESP, and increments otherwise.
  - When it reaches TIMEOUT_CYC: rsp_timeout pulses for 1 cycle, rsp_data holds the partial bytes, and the FSM goes to IDLE.
  - If rx_valid arrives in the same cycle the counter reaches TIMEOUT_CYC, the byte wins and the counter clears.
- Stray bytes: rx_valid in IDLE, SEND or FIN pulses rx_stray and is discarded. In RESP, a byte is never stray.

Decomposition:
- Package sys_cmd_pkg holds:
  - cmd_type encodings.
  - Frame opcodes AA/BB/CC/DD.
  - FSM state encoding.
  - A function giving frame length and expected response count per cmd_type.
- Sub-module sys_cmd_frame_ser: byte-index counter plus tx valid/ready stage, with a load/done interface to the FSM.

Test Plan:
- REG_WR addr=3, wdata=0x81, tx_ready=1 -> tx bytes AA,03,81 in cycles N+1..N+3; rsp_valid in N+4 with rsp_data=0x0000; no rx_stray.
- REG_RD addr=2 with tx_ready toggling 1/0, then rx 0x5C -> bytes BB,02 held stable across stalls; rsp_valid one cycle after rx with rsp_data=0x005C.
- ALU_OP a=0x12, b=0x34, fun=0 -> tx bytes CC,12,34,00; rx 0x46 then 0x00 -> rsp_data=0x0046; cmd_ready=0 throughout and 1 after FIN.
- ALU_NOP fun=2 with TIMEOUT_CYC=8, rx 0xAB only -> after 8 idle cycles rsp_timeout pulses once, rsp_data=0x00AB, rsp_valid never asserts, block back in IDLE.
- rx_valid pulse in IDLE and during SEND -> rx_stray pulses each time and rsp_data is unchanged; a subsequent REG_RD completes normally.
- RST asserted during ALU_OP SEND after 2 bytes -> all outputs at reset values immediately; after release a new REG_RD completes correctly.

Source files
------------

// File: rtl/sys_cmd_pkg.sv
// rtl/sys_cmd_pkg.sv - shared encodings and frame helpers for the UART command master
package sys_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_REG_WR  = 2'd0,
        CMD_REG_RD  = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    localparam logic [7:0] OPC_REG_WR  = 8'hAA;
    localparam logic [7:0] OPC_REG_RD  = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0] frame_len;
        logic [1:0] rsp_cnt;
    } frame_info_t;

    // Number of bytes sent and number of response bytes expected per command.
    function automatic frame_info_t frame_info(input cmd_type_e t);
        frame_info_t fi;
        fi = '0;
        case (t)
            CMD_REG_WR:  begin fi.frame_len = 3'd3; fi.rsp_cnt = 2'd0; end
            CMD_REG_RD:  begin fi.frame_len = 3'd2; fi.rsp_cnt = 2'd1; end
            CMD_ALU_OP:  begin fi.frame_len = 3'd4; fi.rsp_cnt = 2'd2; end
            CMD_ALU_NOP: begin fi.frame_len = 3'd2; fi.rsp_cnt = 2'd2; end
            default:     fi = '0;
        endcase
        return fi;
    endfunction

    // Frame bytes packed little-endian: byte k of the frame sits in bits [8k+7:8k].
    function automatic logic [31:0] build_frame(
        input cmd_type_e  t,
        input logic [3:0] addr,
        input logic [7:0] wdata,
        input logic [7:0] op_a,
        input logic [7:0] op_b,
        input logic [3:0] fun
    );
        logic [31:0] f;
        f = '0;
        case (t)
            CMD_REG_WR:  f = {8'h00, wdata, {4'h0, addr}, OPC_REG_WR};
            CMD_REG_RD:  f = {16'h0000, {4'h0, addr}, OPC_REG_RD};
            CMD_ALU_OP:  f = {{4'h0, fun}, op_b, op_a, OPC_ALU_OP};
            CMD_ALU_NOP: f = {16'h0000, {4'h0, fun}, OPC_ALU_NOP};
            default:     f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sys_cmd_master_if.sv
// rtl/sys_cmd_master_if.sv - command, UART byte and response signals of sys_cmd_master
// master modport: the command master itself; slave modport: the host/UART side.
interface sys_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [7:0]  cmd_op_a;
    logic [7:0]  cmd_op_b;
    logic [3:0]  cmd_fun;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [15:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_timeout;
    logic        rx_stray;

    modport master (
        input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_fun,
        input  tx_ready, rx_byte, rx_valid,
        output cmd_ready, tx_byte, tx_valid, rsp_data, rsp_valid, rsp_timeout, rx_stray
    );

    modport slave (
        output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_fun,
        output tx_ready, rx_byte, rx_valid,
        input  cmd_ready, tx_byte, tx_valid, rsp_data, rsp_valid, rsp_timeout, rx_stray
    );
endinterface

// File: rtl/sys_cmd_frame_ser.sv
// rtl/sys_cmd_frame_ser.sv - byte serializer presenting a loaded frame on a valid/ready byte port
// Ports: clk_i, rst_ni (async active-low); load_i/frame_i/len_i start a frame;
//        tx_ready_i, tx_byte_o, tx_valid_o byte handshake; done_o marks the last transfer.
module sys_cmd_frame_ser (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] frame_i,
    input  logic [2:0]  len_i,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_byte_o,
    output logic        tx_valid_o,
    output logic        done_o
);

    logic [31:0] frame_q;
    logic [2:0]  len_q;
    logic [2:0]  idx_q;
    logic [7:0]  byte_q;
    logic        valid_q;

    logic        xfer;
    logic        last;
    logic [2:0]  idx_nxt;
    logic [7:0]  byte_nxt;

    assign xfer     = valid_q && tx_ready_i;
    assign last     = (idx_q == (len_q - 3'd1));
    assign idx_nxt  = idx_q + 3'd1;
    assign byte_nxt = frame_q[{idx_nxt[1:0], 3'b000} +: 8];
    assign done_o   = xfer && last;

    assign tx_byte_o  = byte_q;
    assign tx_valid_o = valid_q;

    // The byte register only changes on load or on a completed transfer,
    // so tx_byte stays put while the UART stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            frame_q <= frame_i;
            len_q   <= len_i;
            idx_q   <= '0;
            byte_q  <= frame_i[7:0];
            valid_q <= 1'b1;
        end else if (xfer) begin
            idx_q <= idx_nxt;
            if (last) begin
                valid_q <= 1'b0;
                byte_q  <= '0;
            end else begin
                byte_q  <= byte_nxt;
            end
        end
    end

endmodule

// File: rtl/sys_cmd_master.sv
// rtl/sys_cmd_master.sv - host-side UART command initiator: frames commands, gathers responses
// Ports: CLK, RST (async active-low); bus (sys_cmd_master_if.master) carrying the command
//        request, UART TX/RX bytes, assembled response, timeout and stray-byte pulses.
module sys_cmd_master
    import sys_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65535,
    parameter int TO_W        = 16
) (
    input  logic               CLK,
    input  logic               RST,
    sys_cmd_master_if.master   bus
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_e          state_q;
    logic            cmd_ready_q;
    logic [15:0]     rsp_data_q;
    logic            rsp_valid_q;
    logic            rsp_timeout_q;
    logic            rx_stray_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [1:0]      rx_cnt_q;
    logic [1:0]      exp_q;

    logic            accept;
    cmd_type_e       type_in;
    frame_info_t     info_in;
    logic [31:0]     frame_in;
    logic            ser_done;

    assign accept   = bus.cmd_valid && cmd_ready_q;
    assign type_in  = cmd_type_e'(bus.cmd_type);
    assign info_in  = frame_info(type_in);
    assign frame_in = build_frame(type_in, bus.cmd_addr, bus.cmd_wdata,
                                  bus.cmd_op_a, bus.cmd_op_b, bus.cmd_fun);

    // The serializer captures the whole frame on accept, which is where the
    // command fields get registered.
    sys_cmd_frame_ser u_ser (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .load_i     (accept),
        .frame_i    (frame_in),
        .len_i      (info_in.frame_len),
        .tx_ready_i (bus.tx_ready),
        .tx_byte_o  (bus.tx_byte),
        .tx_valid_o (bus.tx_valid),
        .done_o     (ser_done)
    );

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.rx_stray    = rx_stray_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rx_stray_q    <= 1'b0;
            to_cnt_q      <= '0;
            rx_cnt_q      <= '0;
            exp_q         <= '0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            // Only RESP consumes rx bytes; anything else is reported and dropped.
            rx_stray_q    <= bus.rx_valid && (state_q != ST_RESP);

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_SEND;
                        cmd_ready_q <= 1'b0;
                        rsp_data_q  <= '0;
                        rx_cnt_q    <= '0;
                        exp_q       <= info_in.rsp_cnt;
                    end
                end

                ST_SEND: begin
                    if (ser_done) begin
                        if (exp_q == 2'd0) begin
                            state_q     <= ST_FIN;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q  <= ST_RESP;
                            to_cnt_q <= '0;
                        end
                    end
                end

                ST_RESP: begin
                    // An arriving byte beats an expiring counter in the same cycle.
                    if (bus.rx_valid) begin
                        to_cnt_q <= '0;
                        rx_cnt_q <= rx_cnt_q + 2'd1;
                        if (rx_cnt_q[0]) begin
                            rsp_data_q[15:8] <= bus.rx_byte;
                        end else begin
                            rsp_data_q[7:0]  <= bus.rx_byte;
                        end
                        if ((rx_cnt_q + 2'd1) == exp_q) begin
                            state_q     <= ST_FIN;
                            rsp_valid_q <= 1'b1;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q       <= ST_IDLE;
                        cmd_ready_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        to_cnt_q      <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end

                ST_FIN: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
